clock_control_bank: RTL

// - NUM_CH independent gated/divided clock channels driven from one source clock.
// - Per channel: async enable synchroniser, any integer divide ratio 1..2^DIV_W, ratio change only at period boundary.
// - Start/stop is glitch-free: no truncated high pulse, first/last pulse always full width.
// - Sits between the PLL/root clock and peripheral clock domains; successor to the single-slice clock controller.

---
 rtl/clock_control_pkg.sv | 15 +
 rtl/clock_control_channel.sv | 152 +++++++++++++++
 rtl/clock_control_bank.sv | 36 +++
 3 files changed

// File: rtl/clock_control_pkg.sv
// Shared types and constants for the clock control bank and its channels.
package clock_control_pkg;

    // Per-channel life cycle: OFF (output parked low), RUN (clocking),
    // STOPPING (finishing the current period before parking).
    typedef enum logic [1:0] {
        CC_OFF      = 2'd0,
        CC_RUN      = 2'd1,
        CC_STOPPING = 2'd2
    } cc_state_e;

    // Shallowest enable synchroniser that still gives metastability margin.
    localparam int CC_MIN_SYNC = 2;

endpackage : clock_control_pkg

// File: rtl/clock_control_channel.sv
// One gated/divided clock channel: enable synchroniser, run/stop FSM,
// period counter, ratio register, divided-clock flop and the N=1 ICG latch.
// Start and stop only ever happen on period boundaries, so every pulse leaving
// the channel is full width; only an asynchronous reset may truncate a pulse.
module clock_control_channel
    import clock_control_pkg::*;
#(
    parameter int DIV_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sw_enable,
    input  logic [DIV_W-1:0] i_div_sel,
    output logic             o_clk_out,
    output logic             o_is_enabled,
    output logic             o_busy
);

    // A request for fewer stages than the minimum is quietly raised to it.
    localparam int SYNC_N = (SYNC_STAGES < CC_MIN_SYNC) ? CC_MIN_SYNC : SYNC_STAGES;

    logic [SYNC_N-1:0] r_sync;
    logic              w_en_s;

    cc_state_e         r_state;
    cc_state_e         w_state_nxt;
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  w_cnt_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_nxt;
    logic              w_wrap;

    logic              r_clk_div;
    logic              w_clk_div_nxt;
    logic              r_is_enabled;
    logic              r_busy;

    logic              w_gate_d;
    logic              r_gate;

    // Enable synchroniser: the only logic that samples the raw asynchronous enable.
    // NOTE: every clocked register uses <= so all flops update from pre-edge values;
    // blocking assignments here would make the shift chain collapse in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], i_sw_enable};
        end
    end

    assign w_en_s = r_sync[SYNC_N-1];
    assign w_wrap = (r_cnt == r_div);

    // Next-state, counter and ratio-capture logic.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch by accident.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        unique case (r_state)
            CC_OFF: begin
                w_cnt_nxt = '0;
                if (w_en_s) begin
                    w_state_nxt = CC_RUN;
                    w_div_nxt   = i_div_sel;
                end
            end
            CC_RUN: begin
                if (!w_en_s) begin
                    if (w_wrap) begin
                        // Already on the boundary: nothing left to finish.
                        w_state_nxt = CC_OFF;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = CC_STOPPING;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end else if (w_wrap) begin
                    // Period boundary: the only point a new ratio is accepted.
                    w_cnt_nxt = '0;
                    w_div_nxt = i_div_sel;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            CC_STOPPING: begin
                // Re-enable is ignored here; OFF must be reached first.
                if (w_wrap) begin
                    w_state_nxt = CC_OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = CC_OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Divided clock is high for cnt in [0, ceil(N/2)-1], i.e. while 2*cnt <= N-1.
    // Computed from next-state values so the flop is aligned with the counter.
    assign w_clk_div_nxt = (w_state_nxt != CC_OFF) && (w_div_nxt != '0) &&
                           ({w_cnt_nxt, 1'b0} <= {1'b0, w_div_nxt});

    // Channel state registers, divided-clock flop and registered status decodes.
    // NOTE: only control registers get the async reset; there is no memory here
    // whose contents would need clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= CC_OFF;
            r_cnt        <= '0;
            r_div        <= '0;
            r_clk_div    <= 1'b0;
            r_is_enabled <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_div        <= w_div_nxt;
            r_clk_div    <= w_clk_div_nxt;
            r_is_enabled <= (w_state_nxt == CC_RUN);
            r_busy       <= (w_state_nxt == CC_STOPPING);
        end
    end

    // The ratio select is folded into the latch input rather than gating the
    // output directly, so a ratio switch at a posedge cannot chop the high phase
    // already in flight; the N=1 path sees the change from the next posedge.
    assign w_gate_d = (r_state == CC_RUN) && (r_div == '0);

    // ICG latch for the undivided path: transparent while clk is low.
    // NOTE: this is the one deliberate latch; it holds the gate stable through
    // the high phase of clk so the gated pulse is never cut short.
    always_latch begin
        if (!rst_n) begin
            r_gate <= 1'b0;
        end else if (!clk) begin
            r_gate <= w_gate_d;
        end
    end

    // Each path is already low when not selected, so a plain OR merges them.
    assign o_clk_out    = r_clk_div | (clk & r_gate);
    assign o_is_enabled = r_is_enabled;
    assign o_busy       = r_busy;

endmodule : clock_control_channel

// File: rtl/clock_control_bank.sv
// Bank of NUM_CH independent gated/divided clock channels fed from one source
// clock. rst_n asserts asynchronously; its release is expected to arrive
// already aligned to clk from the reset controller.
module clock_control_bank
    import clock_control_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 4,
    parameter int SYNC_STAGES = CC_MIN_SYNC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       sw_enable,
    input  logic [NUM_CH*DIV_W-1:0] div_sel,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       is_enabled,
    output logic [NUM_CH-1:0]       busy
);

    // Channels share nothing but clk and rst_n.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_control_channel #(
            .DIV_W       (DIV_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_sw_enable  (sw_enable[g]),
            .i_div_sel    (div_sel[g*DIV_W +: DIV_W]),
            .o_clk_out    (clk_out[g]),
            .o_is_enabled (is_enabled[g]),
            .o_busy       (busy[g])
        );
    end

endmodule : clock_control_bank
